serial_subtractor: RTL and testbench

//  Multi-cycle signed two's-complement subtractor: diff = a - b - bin, DIGIT bits per clock.

---
 rtl/serial_subtractor_pkg.sv | 22 ++
 rtl/serial_subtractor_slice.sv | 16 +
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM states and derived sizing helpers.
package serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DIGIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed to walk the full operand width.
    function automatic int unsigned digit_count(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    function automatic int unsigned count_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_slice.sv
// Combinational DIGIT-bit adder reused every RUN cycle of the serial subtractor.
module digit_sub_slice #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    always_comb begin
        {cout, s} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle signed subtractor: diff = a - b - bin, computed as a + ~b + ~bin one digit per cycle.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int unsigned N    = digit_count(WIDTH, DIGIT);
    localparam int unsigned CW   = count_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state, state_next;

    logic [WIDTH-1:0]       a_sh;
    logic [WIDTH-1:0]       nb_sh;
    logic [WIDTH-1:0]       res_sh;
    logic [CW-1:0]          cnt;
    logic                   carry;
    logic                   a_sign;
    logic                   b_sign;
    logic [DIGIT-1:0]       sum;
    logic                   cout;
    logic                   accept;
    logic                   last;
    logic [WIDTH+DIGIT-1:0] joined;
    logic [WIDTH-1:0]       assembled;

    digit_sub_slice #(.DIGIT(DIGIT)) u_slice (
        .x    (a_sh[DIGIT-1:0]),
        .y    (nb_sh[DIGIT-1:0]),
        .cin  (carry),
        .s    (sum),
        .cout (cout)
    );

    // New digit enters at the MSB; on the last cycle this is already the full result.
    always_comb begin
        joined    = {sum, res_sh};
        assembled = WIDTH'(joined >> DIGIT);
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        last       = (cnt == LAST);
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            nb_sh    <= '0;
            res_sh   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            a_sign   <= 1'b0;
            b_sign   <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            nb_sh  <= ~b;
            carry  <= ~bin;
            cnt    <= '0;
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
        end else if (state == RUN) begin
            a_sh   <= a_sh >> DIGIT;
            nb_sh  <= nb_sh >> DIGIT;
            carry  <= cout;
            res_sh <= assembled;
            cnt    <= cnt + CW'(1);
            if (last) begin
                diff     <= assembled;
                bout     <= ~cout;
                overflow <= (a_sign != b_sign) && (assembled[WIDTH-1] != a_sign);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: three subtractor instances (DIGIT=4, 1, 32) against an arithmetic model.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_v = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        bin = 1'b0;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [31:0] diff_v [3];
    logic [2:0]  bout_v;
    logic [2:0]  ovf_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(32), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .bin(bin),
        .busy(busy_v[0]), .done(done_v[0]), .diff(diff_v[0]), .bout(bout_v[0]), .overflow(ovf_v[0])
    );
    serial_subtractor #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b), .bin(bin),
        .busy(busy_v[1]), .done(done_v[1]), .diff(diff_v[1]), .bout(bout_v[1]), .overflow(ovf_v[1])
    );
    serial_subtractor #(.WIDTH(32), .DIGIT(32)) u_d32 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .bin(bin),
        .busy(busy_v[2]), .done(done_v[2]), .diff(diff_v[2]), .bout(bout_v[2]), .overflow(ovf_v[2])
    );

    function automatic int run_cycles(input int k);
        case (k)
            0: return 8;
            1: return 32;
            default: return 1;
        endcase
    endfunction

    // Returns {overflow, bout, diff} from plain arithmetic on the operands.
    function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv, input logic binv);
        logic [31:0] d;
        logic        br;
        logic        ov;
        d  = av - bv - {31'd0, binv};
        br = ({32'd0, av} < ({32'd0, bv} + {63'd0, binv}));
        ov = (av[31] != bv[31]) && (d[31] != av[31]);
        return {ov, br, d};
    endfunction

    task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                          input logic binv, input string name);
        logic [33:0] exp;
        logic [31:0] prev;
        int lat, busy_cnt;
        bit seen, hold_bad;
        exp = model(av, bv, binv);
        @(negedge clk);
        a = av; b = bv; bin = binv; start_v[k] = 1'b1;
        prev = diff_v[k];
        @(negedge clk);
        start_v[k] = 1'b0;
        a = $urandom; b = $urandom; bin = 1'($urandom);
        lat = 1; busy_cnt = 0; seen = 0; hold_bad = 0;
        while (!seen && lat < 80) begin
            if (done_v[k]) seen = 1;
            else begin
                if (busy_v[k]) busy_cnt++;
                if (diff_v[k] !== prev) hold_bad = 1;
                @(negedge clk);
                lat++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles, required %0d", name, lat, run_cycles(k) + 1);
        end
        checks++;
        if (lat !== run_cycles(k) + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, run_cycles(k) + 1);
        end
        checks++;
        if (busy_cnt !== run_cycles(k)) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, run_cycles(k));
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL %s diff_hold: diff changed during RUN, required %0h", name, prev);
        end
        checks++;
        if (diff_v[k] !== exp[31:0]) begin
            errors++;
            $display("FAIL %s diff: got %0h required %0h", name, diff_v[k], exp[31:0]);
        end
        checks++;
        if (bout_v[k] !== exp[32]) begin
            errors++;
            $display("FAIL %s bout: got %b required %b", name, bout_v[k], exp[32]);
        end
        checks++;
        if (ovf_v[k] !== exp[33]) begin
            errors++;
            $display("FAIL %s overflow: got %b required %b", name, ovf_v[k], exp[33]);
        end
        checks++;
        if (busy_v[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b required 0", name, busy_v[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({busy_v[k], done_v[k], diff_v[k], bout_v[k], ovf_v[k]} !== 35'd0) begin
                errors++;
                $display("FAIL reset[%0d]: got busy=%b done=%b diff=%0h bout=%b ovf=%b required all 0",
                         k, busy_v[k], done_v[k], diff_v[k], bout_v[k], ovf_v[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        for (int k = 0; k < 3; k++) begin
            run_op(k, 32'h8000_0000, 32'd1, 1'b0, $sformatf("case1_k%0d", k));
            run_op(k, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, $sformatf("case2_k%0d", k));
            run_op(k, 32'd52, 32'd31, 1'b0, $sformatf("case3_k%0d", k));
            run_op(k, 32'd0, 32'd0, 1'b1, $sformatf("case4a_k%0d", k));
            run_op(k, 32'(-4548), 32'(-495955), 1'b0, $sformatf("case4b_k%0d", k));
        end
        checks++;
        if (diff_v[0] !== 32'd491407) begin
            errors++;
            $display("FAIL case4b_const: got %0d required 491407", diff_v[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [4];
        logic [31:0] av, bv;
        corner[0] = 32'h8000_0000; corner[1] = 32'h7FFF_FFFF;
        corner[2] = 32'h0000_0000; corner[3] = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) begin
                av = (i % 3 == 0) ? corner[$urandom_range(3, 0)] : $urandom;
                bv = (i % 4 == 1) ? corner[$urandom_range(3, 0)] : $urandom;
                run_op(k, av, bv, 1'($urandom), $sformatf("rand_k%0d_%0d", k, i));
            end
        end
    endtask

    task automatic test_ignore_and_abort();
        int wait_cnt;
        bit seen;
        @(negedge clk);
        a = 32'd52; b = 32'd31; bin = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);                     // RUN cycle 1
        start_v[0] = 1'b0;
        @(negedge clk);                     // RUN cycle 2
        @(negedge clk);                     // RUN cycle 3
        a = 32'd999; b = 32'd5; bin = 1'b1; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        seen = 0; wait_cnt = 0;
        while (!seen && wait_cnt < 20) begin
            if (done_v[0]) seen = 1;
            else begin @(negedge clk); wait_cnt++; end
        end
        checks++;
        if (!seen || diff_v[0] !== 32'd21 || bout_v[0] !== 1'b0 || ovf_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: seen=%b diff=%0d bout=%b ovf=%b required diff=21 bout=0 ovf=0",
                     seen, diff_v[0], bout_v[0], ovf_v[0]);
        end
        @(negedge clk);
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL no_queue: got busy=%b done=%b required 0 0", busy_v[0], done_v[0]);
        end
        a = 32'd1000; b = 32'd1; bin = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);                     // RUN cycle 1
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);          // RUN cycle 5
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got busy=%b required 1", busy_v[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b0 || diff_v[0] !== 32'd0 || bout_v[0] !== 1'b0 || ovf_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort: got busy=%b diff=%0h bout=%b ovf=%b required all 0",
                     busy_v[0], diff_v[0], bout_v[0], ovf_v[0]);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done_v[0]) seen = 1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_done: got done pulse required none");
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        bit ok1, ok2;
        @(negedge clk);
        a = 32'd4561; b = 32'd89; bin = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        a = 32'(-451); b = 32'(-4498);
        lat1 = 1; ok1 = 0;
        while (!ok1 && lat1 < 40) begin
            if (done_v[0]) ok1 = 1;
            else begin @(negedge clk); lat1++; end
        end
        checks++;
        if (!ok1 || lat1 !== 9 || diff_v[0] !== 32'd4472) begin
            errors++;
            $display("FAIL b2b_first: done=%b lat=%0d diff=%0d required lat=9 diff=4472", ok1, lat1, diff_v[0]);
        end
        @(negedge clk);
        start_v[0] = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rerun: got busy=%b done=%b required 1 0", busy_v[0], done_v[0]);
        end
        lat2 = 1; ok2 = 0;
        while (!ok2 && lat2 < 40) begin
            if (done_v[0]) ok2 = 1;
            else begin @(negedge clk); lat2++; end
        end
        checks++;
        if (!ok2 || lat2 !== 9 || diff_v[0] !== 32'd4047) begin
            errors++;
            $display("FAIL b2b_second: done=%b lat=%0d diff=%0d required lat=9 diff=4047", ok2, lat2, diff_v[0]);
        end
        @(negedge clk);
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b done=%b required 0 0", busy_v[0], done_v[0]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_and_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
